// File: rtl/db_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : db_arb_pkg
// Description : Shared defaults and port-ID type for the database arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package db_arb_pkg;

    localparam int c_KEY_SIZE = 96;
    localparam int c_FLAG_W   = 4;
    localparam int c_DEPTH    = 8;

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } port_id_t;

endpackage
`default_nettype wire

// File: rtl/db_arb_tagfifo.sv
`default_nettype none
// ============================================================================
// Module      : db_arb_tagfifo
// Description : 1-bit in-order tag FIFO remembering which port owns each lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module db_arb_tagfifo
    import db_arb_pkg::*;
#(
    parameter int DEPTH = c_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_din,
    input  logic                     i_pop,
    output logic                     o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH_CNT = (c_AW+1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_DEPTH_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers are exactly c_AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/db_arb.sv
`default_nettype none
// ============================================================================
// Module      : db_arb
// Description : Two-port round-robin arbiter in front of an in-order database.
// Revision    : 1.0 - initial release
// ============================================================================
module db_arb
    import db_arb_pkg::*;
#(
    parameter int KEY_SIZE = c_KEY_SIZE,
    parameter int FLAG_W   = c_FLAG_W,
    parameter int DEPTH    = c_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [KEY_SIZE-1:0]     p0_key,
    input  logic [FLAG_W-1:0]       p0_flag,
    input  logic                    p0_valid,
    output logic                    p0_ready,
    input  logic [KEY_SIZE-1:0]     p1_key,
    input  logic [FLAG_W-1:0]       p1_flag,
    input  logic                    p1_valid,
    output logic                    p1_ready,
    output logic [KEY_SIZE-1:0]     in_key,
    output logic [FLAG_W-1:0]       in_flag,
    output logic                    in_valid,
    input  logic                    out_valid,
    input  logic [FLAG_W-1:0]       out_flag,
    output logic                    p0_resp_valid,
    output logic [FLAG_W-1:0]       p0_resp_flag,
    output logic                    p1_resp_valid,
    output logic [FLAG_W-1:0]       p1_resp_flag,
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic                    orphan_err
);

    port_id_t r_last;
    logic     w_full;
    logic     w_empty;
    logic     w_head;
    logic     w_can_grant;
    logic     w_xfer;
    logic     w_pop;
    logic     w_orphan;

    // Grant is gated by the registered count, so a same-cycle pop never frees a slot early.
    assign w_can_grant = rst_n && !w_full;
    assign p0_ready    = w_can_grant && p0_valid && (!p1_valid || (r_last == P1));
    assign p1_ready    = w_can_grant && p1_valid && (!p0_valid || (r_last == P0));
    assign w_xfer      = p0_ready || p1_ready;
    assign w_pop       = out_valid && !w_empty;
    assign w_orphan    = out_valid && w_empty;

    db_arb_tagfifo #(
        .DEPTH (DEPTH)
    ) u_tagfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_xfer),
        .i_din   (p1_ready),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last        <= P1;
            in_valid      <= 1'b0;
            in_key        <= '0;
            in_flag       <= '0;
            p0_resp_valid <= 1'b0;
            p0_resp_flag  <= '0;
            p1_resp_valid <= 1'b0;
            p1_resp_flag  <= '0;
            orphan_err    <= 1'b0;
        end else begin
            in_valid <= w_xfer;
            if (p0_ready) begin
                in_key  <= p0_key;
                in_flag <= p0_flag;
                r_last  <= P0;
            end else if (p1_ready) begin
                in_key  <= p1_key;
                in_flag <= p1_flag;
                r_last  <= P1;
            end

            p0_resp_valid <= w_pop && (w_head == P0);
            p1_resp_valid <= w_pop && (w_head == P1);
            if (w_pop) begin
                if (w_head == P1) begin
                    p1_resp_flag <= out_flag;
                end else begin
                    p0_resp_flag <= out_flag;
                end
            end

            if (w_orphan) begin
                orphan_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_db_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_db_arb
// Description : Scoreboard-driven self-checking bench for db_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_db_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] p0_key, p1_key, in_key;
    logic [3:0]  p0_flag, p1_flag, in_flag, out_flag, p0_resp_flag, p1_resp_flag;
    logic        p0_valid, p1_valid, p0_ready, p1_ready, in_valid, out_valid;
    logic        p0_resp_valid, p1_resp_valid, orphan_err;
    logic [3:0]  outstanding;

    always #5 clk = ~clk;

    db_arb u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .p0_key        (p0_key),
        .p0_flag       (p0_flag),
        .p0_valid      (p0_valid),
        .p0_ready      (p0_ready),
        .p1_key        (p1_key),
        .p1_flag       (p1_flag),
        .p1_valid      (p1_valid),
        .p1_ready      (p1_ready),
        .in_key        (in_key),
        .in_flag       (in_flag),
        .in_valid      (in_valid),
        .out_valid     (out_valid),
        .out_flag      (out_flag),
        .p0_resp_valid (p0_resp_valid),
        .p0_resp_flag  (p0_resp_flag),
        .p1_resp_valid (p1_resp_valid),
        .p1_resp_flag  (p1_resp_flag),
        .outstanding   (outstanding),
        .orphan_err    (orphan_err)
    );

    typedef struct { logic [95:0] key; logic [3:0] flag; } req_t;
    typedef struct { logic port; logic [3:0] flag; } resp_t;

    int    vectors    = 0;
    int    miscompares = 0;
    req_t  req_q[$];
    resp_t resp_q[$];
    logic  tag_q[$];
    int    m_cnt      = 0;
    logic  m_last     = 1'b1;
    logic  m_orphan   = 1'b0;
    logic  exp_r0, exp_r1, exp_inv, exp_rv0, exp_rv1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: previous winner loses a tie; nothing granted when full.
    task automatic eval_model();
        logic can;
        can    = rst_n && (m_cnt < 8);
        exp_r0 = can && p0_valid && (!p1_valid || m_last);
        exp_r1 = can && p1_valid && (!p0_valid || !m_last);
    endtask

    task automatic advance();
        req_t  r;
        resp_t s;
        eval_model();
        exp_inv = exp_r0 || exp_r1;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        if (!rst_n) begin
            req_q.delete();
            resp_q.delete();
            tag_q.delete();
            m_last   = 1'b1;
            m_orphan = 1'b0;
            m_cnt    = 0;
            exp_inv  = 1'b0;
        end else begin
            if (out_valid) begin
                if (tag_q.size() > 0) begin
                    s.port  = tag_q.pop_front();
                    s.flag  = out_flag;
                    resp_q.push_back(s);
                    exp_rv0 = !s.port;
                    exp_rv1 = s.port;
                end else begin
                    m_orphan = 1'b1;
                end
            end
            if (exp_inv) begin
                r.key  = exp_r0 ? p0_key : p1_key;
                r.flag = exp_r0 ? p0_flag : p1_flag;
                req_q.push_back(r);
                tag_q.push_back(exp_r1);
                m_last = exp_r1;
            end
            m_cnt = tag_q.size();
        end
        tick();
    endtask

    task automatic idle_inputs();
        p0_valid  = 1'b0;
        p1_valid  = 1'b0;
        out_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        p0_valid  = 1'b1;
        p1_valid  = 1'b1;
        out_valid = 1'b1;
        out_flag  = 4'h6;
        #1;
        vectors++;
        if ({p0_ready, p1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 00", {p0_ready, p1_ready});
        end
        advance();
        advance();
        vectors++;
        if ({in_valid, p0_resp_valid, p1_resp_valid, orphan_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {in_valid, p0_resp_valid, p1_resp_valid, orphan_err});
        end
        vectors++;
        if ({in_key, in_flag, p0_resp_flag, p1_resp_flag} !== 108'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected zeros",
                     in_key, in_flag, p0_resp_flag, p1_resp_flag);
        end
        vectors++;
        if (outstanding !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_outstanding: got %0d expected 0", outstanding);
        end
        rst_n = 1'b1;
        idle_inputs();
        advance();
    endtask

    task automatic test_data_integrity();
        logic [95:0] a5;
        req_t  r;
        resp_t s;
        a5       = {12{8'hA5}};
        p1_key   = a5;
        p1_flag  = 4'h2;
        p1_valid = 1'b1;
        #1;
        eval_model();
        vectors++;
        if ({p0_ready, p1_ready} !== {exp_r0, exp_r1}) begin
            miscompares++;
            $display("FAIL data_ready: got %b expected %b", {p0_ready, p1_ready}, {exp_r0, exp_r1});
        end
        advance();
        p1_valid = 1'b0;
        p1_key   = '1;
        p1_flag  = 4'hF;
        r = req_q.pop_front();
        vectors++;
        if ({in_valid, in_key, in_flag} !== {1'b1, r.key, r.flag}) begin
            miscompares++;
            $display("FAIL data_req: got %b/%h/%h expected 1/%h/%h", in_valid, in_key, in_flag, r.key, r.flag);
        end
        out_valid = 1'b1;
        out_flag  = 4'h9;
        advance();
        out_valid = 1'b0;
        vectors++;
        if ({in_valid, in_key, in_flag} !== {1'b0, a5, 4'h2}) begin
            miscompares++;
            $display("FAIL data_hold: got %b/%h/%h expected 0/%h/2", in_valid, in_key, in_flag, a5);
        end
        s = resp_q.pop_front();
        vectors++;
        if ({p0_resp_valid, p1_resp_valid, p1_resp_flag} !== {1'b0, 1'b1, s.flag}) begin
            miscompares++;
            $display("FAIL data_resp: got %b%b/%h expected 01/%h", p0_resp_valid, p1_resp_valid, p1_resp_flag, s.flag);
        end
        advance();
        vectors++;
        if ({p1_resp_valid, p1_resp_flag, outstanding} !== {1'b0, 4'h9, 4'd0}) begin
            miscompares++;
            $display("FAIL data_resp_hold: got %b/%h/%0d expected 0/9/0", p1_resp_valid, p1_resp_flag, outstanding);
        end
    endtask

    task automatic test_alternation();
        logic  ov_sched[0:31];
        req_t  r;
        resp_t s;
        for (int i = 0; i < 32; i++) ov_sched[i] = 1'b0;
        for (int c = 0; c < 15; c++) begin
            p0_valid  = (c < 8);
            p1_valid  = (c < 8);
            p0_key    = {$urandom, $urandom, $urandom};
            p1_key    = {$urandom, $urandom, $urandom};
            p0_flag   = 4'($urandom);
            p1_flag   = 4'($urandom);
            out_valid = ov_sched[c];
            out_flag  = 4'($urandom);
            #1;
            eval_model();
            vectors++;
            if ({p0_ready, p1_ready} !== {exp_r0, exp_r1}) begin
                miscompares++;
                $display("FAIL alt_ready c=%0d: got %b expected %b", c, {p0_ready, p1_ready}, {exp_r0, exp_r1});
            end
            if (c < 8) begin
                vectors++;
                if (p1_ready !== 1'(c % 2)) begin
                    miscompares++;
                    $display("FAIL alt_order c=%0d: p1_ready got %b expected %b", c, p1_ready, 1'(c % 2));
                end
            end
            advance();
            if (exp_inv) ov_sched[c + 5] = 1'b1;
            vectors++;
            if (in_valid !== exp_inv) begin
                miscompares++;
                $display("FAIL alt_in_valid c=%0d: got %b expected %b", c, in_valid, exp_inv);
            end
            if (exp_inv && req_q.size() > 0) begin
                r = req_q.pop_front();
                vectors++;
                if ({in_key, in_flag} !== {r.key, r.flag}) begin
                    miscompares++;
                    $display("FAIL alt_in_data c=%0d: got %h/%h expected %h/%h", c, in_key, in_flag, r.key, r.flag);
                end
            end
            vectors++;
            if ({p0_resp_valid, p1_resp_valid} !== {exp_rv0, exp_rv1}) begin
                miscompares++;
                $display("FAIL alt_resp_valid c=%0d: got %b expected %b", c,
                         {p0_resp_valid, p1_resp_valid}, {exp_rv0, exp_rv1});
            end
            if ((exp_rv0 || exp_rv1) && resp_q.size() > 0) begin
                s = resp_q.pop_front();
                vectors++;
                if ((s.port ? p1_resp_flag : p0_resp_flag) !== s.flag) begin
                    miscompares++;
                    $display("FAIL alt_resp_flag c=%0d: got %h expected %h", c,
                             s.port ? p1_resp_flag : p0_resp_flag, s.flag);
                end
            end
        end
        idle_inputs();
        vectors++;
        if (outstanding !== 4'(m_cnt)) begin
            miscompares++;
            $display("FAIL alt_drained: outstanding got %0d expected %0d", outstanding, m_cnt);
        end
    endtask

    task automatic test_backpressure();
        int    xfers;
        resp_t s;
        do_reset();
        xfers    = 0;
        p0_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            p0_key  = {$urandom, $urandom, $urandom};
            p0_flag = 4'($urandom);
            #1;
            eval_model();
            vectors++;
            if (p0_ready !== exp_r0) begin
                miscompares++;
                $display("FAIL bp_ready c=%0d: got %b expected %b", c, p0_ready, exp_r0);
            end
            if (p0_ready === 1'b1) xfers++;
            advance();
        end
        vectors++;
        if (xfers !== 8 || outstanding !== 4'd8) begin
            miscompares++;
            $display("FAIL bp_full: transfers got %0d outstanding %0d expected 8/8", xfers, outstanding);
        end
        out_valid = 1'b1;
        out_flag  = 4'hC;
        #1;
        vectors++;
        if (p0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_pop_same_cycle: p0_ready got %b expected 0", p0_ready);
        end
        advance();
        out_valid = 1'b0;
        s = resp_q.pop_front();
        vectors++;
        if ({p0_resp_valid, p0_resp_flag, outstanding} !== {1'b1, s.flag, 4'd7}) begin
            miscompares++;
            $display("FAIL bp_pop: got %b/%h/%0d expected 1/%h/7", p0_resp_valid, p0_resp_flag, outstanding, s.flag);
        end
        #1;
        vectors++;
        if (p0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_regrant: p0_ready got %b expected 1", p0_ready);
        end
        p0_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            out_valid = 1'b1;
            out_flag  = 4'($urandom);
            advance();
            s = resp_q.pop_front();
            vectors++;
            if ({p0_resp_valid, p1_resp_valid, p0_resp_flag} !== {1'b1, 1'b0, s.flag}) begin
                miscompares++;
                $display("FAIL bp_drain c=%0d: got %b%b/%h expected 10/%h", c,
                         p0_resp_valid, p1_resp_valid, p0_resp_flag, s.flag);
            end
        end
        idle_inputs();
        vectors++;
        if ({outstanding, orphan_err} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_empty: got %0d/%b expected 0/0", outstanding, orphan_err);
        end
    endtask

    task automatic test_simultaneous();
        req_t  r;
        resp_t s;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            p0_valid = (c != 1);
            p1_valid = (c == 1);
            p0_key   = {$urandom, $urandom, $urandom};
            p1_key   = {$urandom, $urandom, $urandom};
            advance();
            void'(req_q.pop_front());
        end
        p0_valid  = 1'b0;
        p1_valid  = 1'b1;
        p1_key    = {$urandom, $urandom, $urandom};
        p1_flag   = 4'h3;
        out_valid = 1'b1;
        out_flag  = 4'h7;
        #1;
        vectors++;
        if ({p0_ready, p1_ready, outstanding} !== {2'b01, 4'd3}) begin
            miscompares++;
            $display("FAIL sim_pre: got %b%b/%0d expected 01/3", p0_ready, p1_ready, outstanding);
        end
        advance();
        idle_inputs();
        r = req_q.pop_front();
        s = resp_q.pop_front();
        vectors++;
        if (outstanding !== 4'd3) begin
            miscompares++;
            $display("FAIL sim_count: outstanding got %0d expected 3", outstanding);
        end
        vectors++;
        if ({p0_resp_valid, p1_resp_valid, p0_resp_flag} !== {1'b1, 1'b0, 4'h7} || s.port !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_resp: got %b%b/%h expected 10/7", p0_resp_valid, p1_resp_valid, p0_resp_flag);
        end
        vectors++;
        if ({in_valid, in_key, in_flag} !== {1'b1, r.key, r.flag}) begin
            miscompares++;
            $display("FAIL sim_req: got %b/%h/%h expected 1/%h/%h", in_valid, in_key, in_flag, r.key, r.flag);
        end
        for (int c = 0; c < 3; c++) begin
            out_valid = 1'b1;
            out_flag  = 4'(c + 1);
            advance();
            s = resp_q.pop_front();
            vectors++;
            if ({p0_resp_valid, p1_resp_valid} !== {!s.port, s.port} ||
                (s.port ? p1_resp_flag : p0_resp_flag) !== s.flag) begin
                miscompares++;
                $display("FAIL sim_drain c=%0d: got %b%b/%h/%h expected port %b flag %h", c,
                         p0_resp_valid, p1_resp_valid, p0_resp_flag, p1_resp_flag, s.port, s.flag);
            end
        end
        idle_inputs();
    endtask

    task automatic test_orphan();
        do_reset();
        out_valid = 1'b1;
        out_flag  = 4'h5;
        advance();
        out_valid = 1'b0;
        vectors++;
        if ({p0_resp_valid, p1_resp_valid, orphan_err, outstanding} !== {3'b001, 4'd0}) begin
            miscompares++;
            $display("FAIL orphan_set: got %b%b/%b/%0d expected 00/1/0",
                     p0_resp_valid, p1_resp_valid, orphan_err, outstanding);
        end
        p0_valid = 1'b1;
        advance();
        p0_valid = 1'b0;
        advance();
        out_valid = 1'b1;
        advance();
        out_valid = 1'b0;
        advance();
        vectors++;
        if ({orphan_err, outstanding} !== {1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL orphan_sticky: got %b/%0d expected 1/0", orphan_err, outstanding);
        end
        do_reset();
        vectors++;
        if (orphan_err !== 1'b0) begin
            miscompares++;
            $display("FAIL orphan_clear: got %b expected 0", orphan_err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        p0_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            p0_key  = {$urandom, $urandom, $urandom} | 96'h1;
            p0_flag = 4'($urandom) | 4'h1;
            advance();
        end
        p0_valid  = 1'b0;
        out_valid = 1'b1;
        out_flag  = 4'hA;
        advance();
        out_valid = 1'b0;
        vectors++;
        if ({outstanding, p0_resp_flag} !== {4'd5, 4'hA}) begin
            miscompares++;
            $display("FAIL mid_pre: got %0d/%h expected 5/a", outstanding, p0_resp_flag);
        end
        rst_n    = 1'b0;
        p0_valid = 1'b1;
        #1;
        vectors++;
        if (p0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_ready: got %b expected 0", p0_ready);
        end
        advance();
        vectors++;
        if ({in_valid, in_key, in_flag, p0_resp_valid, p0_resp_flag, p1_resp_valid, p1_resp_flag,
             outstanding, orphan_err} !== 116'd0) begin
            miscompares++;
            $display("FAIL mid_clear: in=%b/%h/%h r0=%b/%h r1=%b/%h out=%0d orph=%b expected all 0",
                     in_valid, in_key, in_flag, p0_resp_valid, p0_resp_flag,
                     p1_resp_valid, p1_resp_flag, outstanding, orphan_err);
        end
        rst_n     = 1'b1;
        p0_valid  = 1'b0;
        out_valid = 1'b1;
        out_flag  = 4'h3;
        advance();
        out_valid = 1'b0;
        vectors++;
        if ({p0_resp_valid, p1_resp_valid, orphan_err, outstanding} !== {3'b001, 4'd0}) begin
            miscompares++;
            $display("FAIL mid_orphan: got %b%b/%b/%0d expected 00/1/0",
                     p0_resp_valid, p1_resp_valid, orphan_err, outstanding);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        p0_key    = '0;
        p1_key    = '0;
        p0_flag   = '0;
        p1_flag   = '0;
        out_flag  = '0;
        idle_inputs();
        test_reset();
        test_data_integrity();
        test_alternation();
        test_backpressure();
        test_simultaneous();
        test_orphan();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
